// File: rtl/speck_pkg.sv
// Shared SPECK constants, word type, decryptor FSM states and rotate helpers.
// The encryptor side takes KEY from here too, so both ends always agree on the whitening.
package speck_pkg;

    localparam logic [31:0] KEY   = 32'h0000_1234;
    localparam int          ALPHA = 7;
    localparam int          BETA  = 2;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Shift amounts must stay in 1..15.
    function automatic word_t rol(input word_t x, input int n);
        return (x << n) | (x >> (16 - n));
    endfunction

    function automatic word_t ror(input word_t x, input int n);
        return (x >> n) | (x << (16 - n));
    endfunction

endpackage

// File: rtl/speck_inv_round.sv
// One combinational SPECK inverse round: undoes L' = ROR7(L)+R, R' = ROL2(R)^L'.
module speck_inv_round
    import speck_pkg::*;
(
    input  word_t l_i,
    input  word_t r_i,
    output word_t l_o,
    output word_t r_o
);

    word_t r_prev;

    assign r_prev = ror(r_i ^ l_i, BETA);
    assign r_o    = r_prev;
    // The subtract wraps modulo 2^16; the borrow out is dropped.
    assign l_o    = rol(l_i - r_prev, ALPHA);

endmodule

// File: rtl/speck_dec_core.sv
// Iterative SPECK decryptor: one inverse round per clock, then removes the KEY whitening.
// Optional debug ports (debug_key, debug_round) are built when SPECK_DEC_DEBUG_EN is defined.
module speck_dec_core
    import speck_pkg::*;
#(
    parameter int ROUNDS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] left_in,
    input  logic [15:0] right_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
`ifdef SPECK_DEC_DEBUG_EN
    ,
    output logic [31:0] debug_key,
    output logic [4:0]  debug_round
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid and its data hold until that edge, and ready never depends on valid.

    localparam logic [4:0] CNT_INIT = 5'(ROUNDS - 1);

    state_t      state_q;
    word_t       l_q;
    word_t       r_q;
    word_t       l_d;
    word_t       r_d;
    logic [4:0]  cnt_q;
    logic        out_valid_q;
    logic [31:0] out_data_q;

    speck_inv_round u_round (
        .l_i (l_q),
        .r_i (r_q),
        .l_o (l_d),
        .r_o (r_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            l_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        l_q     <= left_in;
                        r_q     <= right_in;
                        cnt_q   <= CNT_INIT;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    l_q <= l_d;
                    r_q <= r_d;
                    if (cnt_q == 5'd0) begin
                        out_data_q  <= {l_d, r_d} ^ KEY;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gating with rst keeps in_ready low for every cycle reset is held.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef SPECK_DEC_DEBUG_EN
    assign debug_key   = KEY;
    assign debug_round = (state_q == RUN) ? cnt_q : 5'd0;
`endif

endmodule

// File: tb/tb_speck_dec_core.sv
// Bench for speck_dec_core: three instances (ROUNDS = 1, 2, 4) checked against constants
// and a forward-encryptor model through an expected-value queue.
module tb_speck_dec_core;

    logic        clk;
    logic        rst;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [15:0] left_in   [3];
    logic [15:0] right_in  [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] out_data  [3];
    logic        busy      [3];
`ifdef SPECK_DEC_DEBUG_EN
    logic [31:0] debug_key   [3];
    logic [4:0]  debug_round [3];
`endif

    int rnds [3] = '{1, 2, 4};

    logic [31:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    speck_dec_core #(.ROUNDS(1)) u_r1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .left_in(left_in[0]), .right_in(right_in[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
`ifdef SPECK_DEC_DEBUG_EN
        , .debug_key(debug_key[0]), .debug_round(debug_round[0])
`endif
    );

    speck_dec_core #(.ROUNDS(2)) u_r2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .left_in(left_in[1]), .right_in(right_in[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
`ifdef SPECK_DEC_DEBUG_EN
        , .debug_key(debug_key[1]), .debug_round(debug_round[1])
`endif
    );

    speck_dec_core #(.ROUNDS(4)) u_r4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .left_in(left_in[2]), .right_in(right_in[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2])
`ifdef SPECK_DEC_DEBUG_EN
        , .debug_key(debug_key[2]), .debug_round(debug_round[2])
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Forward encryptor: whiten once, then ROUNDS forward rounds.
    function automatic logic [31:0] encrypt(input logic [31:0] pt, input int rounds);
        logic [15:0] l;
        logic [15:0] r;
        {l, r} = pt ^ 32'h0000_1234;
        for (int i = 0; i < rounds; i++) begin
            l = {l[6:0], l[15:7]} + r;
            r = {r[13:0], r[15:14]} ^ l;
        end
        return {l, r};
    endfunction

    // Drive one pair, check latency, optionally stall the output, then check the result.
    task automatic send(input int idx, input logic [15:0] l, input logic [15:0] r,
                        input logic [31:0] exp, input int hold);
        int cyc;
        logic [31:0] got;
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready[idx]), 32'd1);
        in_valid[idx]  = 1'b1;
        left_in[idx]   = l;
        right_in[idx]  = r;
        out_ready[idx] = 1'b0;
        @(posedge clk);
        #1;
        in_valid[idx] = 1'b0;
        left_in[idx]  = 16'($urandom);
        right_in[idx] = 16'($urandom);
        exp_q.push_back(exp);
        check("busy_run", 32'(busy[idx]), 32'd1);
        check("in_ready_run", 32'(in_ready[idx]), 32'd0);
        cyc = 0;
        while (out_valid[idx] !== 1'b1 && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(rnds[idx]));
        check("in_ready_done", 32'(in_ready[idx]), 32'd0);
        got = out_data[idx];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid[idx]), 32'd1);
            check("hold_data", out_data[idx], got);
        end
        if (exp_q.size() > 0) check("out_data", out_data[idx], exp_q.pop_front());
        out_ready[idx] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[idx] = 1'b0;
        check("valid_cleared", 32'(out_valid[idx]), 32'd0);
        check("in_ready_back", 32'(in_ready[idx]), 32'd1);
        check("busy_idle", 32'(busy[idx]), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: run did not complete, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] pt;
        logic [31:0] ct;
        int idx;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            left_in[i]   = '0;
            right_in[i]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_out_valid", 32'(out_valid[i]), 32'd0);
            check("rst_out_data", out_data[i], 32'd0);
            check("rst_busy", 32'(busy[i]), 32'd0);
            check("rst_in_ready", 32'(in_ready[i]), 32'd0);
`ifdef SPECK_DEC_DEBUG_EN
            check("dbg_key", debug_key[i], 32'h0000_1234);
            check("dbg_round_rst", 32'(debug_round[i]), 32'd0);
`endif
        end
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready[0]), 32'd1);

        // Directed vectors.
        send(0, 16'h1234, 16'h5AE4, 32'h0000_0000, 0);
        send(0, 16'h0200, 16'h0200, 32'h0001_1234, 1);
        send(1, 16'hC308, 16'hA899, 32'h0000_0000, 0);
        send(2, encrypt(32'hDEAD_BEEF, 4) >> 16, encrypt(32'hDEAD_BEEF, 4) & 32'hFFFF,
             32'hDEAD_BEEF, 0);

        // Backpressure: a second pair waits on the pins while the first is stalled.
        @(negedge clk);
        in_valid[0] = 1'b1;
        left_in[0]  = 16'h1234;
        right_in[0] = 16'h5AE4;
        @(posedge clk);
        #1;
        left_in[0]  = 16'h0200;
        right_in[0] = 16'h0200;
        exp_q.push_back(32'h0000_0000);
        @(posedge clk);
        #1;
        check("bp_valid", 32'(out_valid[0]), 32'd1);
        check("bp_data", out_data[0], exp_q.pop_front());
        for (int h = 0; h < 5; h++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'(out_valid[0]), 32'd1);
            check("bp_hold_data", out_data[0], 32'h0000_0000);
            check("bp_in_ready", 32'(in_ready[0]), 32'd0);
        end
        out_ready[0] = 1'b1;
        exp_q.push_back(32'h0001_1234);
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        check("bp_hs_valid", 32'(out_valid[0]), 32'd0);
        check("bp_hs_in_ready", 32'(in_ready[0]), 32'd1);
        check("bp_hs_busy", 32'(busy[0]), 32'd0);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        check("bp2_busy", 32'(busy[0]), 32'd1);
        @(posedge clk);
        #1;
        check("bp2_valid", 32'(out_valid[0]), 32'd1);
        check("bp2_data", out_data[0], exp_q.pop_front());
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        check("bp2_cleared", 32'(out_valid[0]), 32'd0);

        // Reset in the second RUN cycle of the ROUNDS = 4 instance.
        @(negedge clk);
        in_valid[2] = 1'b1;
        left_in[2]  = 16'hAAAA;
        right_in[2] = 16'h5555;
        @(posedge clk);
        #1;
        in_valid[2] = 1'b0;
        @(posedge clk);
        #1;
        check("mid_busy", 32'(busy[2]), 32'd1);
`ifdef SPECK_DEC_DEBUG_EN
        check("dbg_round_run", 32'(debug_round[2]), 32'd2);
`endif
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready[2]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_after_in_ready", 32'(in_ready[2]), 32'd1);
        check("mid_after_busy", 32'(busy[2]), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check("mid_no_valid", 32'(out_valid[2]), 32'd0);
        end
        pt = 32'h0BAD_F00D;
        ct = encrypt(pt, 4);
        send(2, ct[31:16], ct[15:0], pt, 0);

        // Round trip through the forward model, with random output stalls.
        for (int i = 0; i < 1000; i++) begin
            idx = i % 3;
            pt  = $urandom;
            ct  = encrypt(pt, rnds[idx]);
            send(idx, ct[31:16], ct[15:0], pt, $urandom_range(0, 2));
        end

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
